// File: rtl/alu_result_stage.sv
// ============================================================================
// Module   : alu_result_stage
// Purpose  : One-entry registered output stage for the 8-bit adder. Holds the
//            sum behind a valid/ready handshake toward writeback, maintains
//            the {V,C,N,Z} flag register (masked updates, multi-byte zero
//            chain, restore path) and evaluates a branch condition.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_result_stage #(
    parameter logic [3:0] RESET_FLAGS = 4'b0000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] sum,
    input  logic       carry,
    input  logic       overflow,
    input  logic [3:0] flag_mask,
    input  logic       chain,
    input  logic       flag_load,
    input  logic [3:0] flag_din,
    input  logic [2:0] cond_sel,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] result,
    output logic [3:0] flags,
    output logic       cond_true
);

    // Flag bit positions inside the {V,C,N,Z} register.
    localparam int unsigned FLAG_Z = 0;
    localparam int unsigned FLAG_N = 1;
    localparam int unsigned FLAG_C = 2;
    localparam int unsigned FLAG_V = 3;

    typedef enum logic [0:0] {
        S_EMPTY = 1'b0,
        S_FULL  = 1'b1
    } state_t;

    state_t     state;
    state_t     state_next;
    logic       accept;
    logic       drain;
    logic       sum_zero;
    logic [3:0] flags_calc;
    logic [3:0] flags_next;

    // Occupancy register; reset discards any held result.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_EMPTY;
        end else begin
            state <= state_next;
        end
    end

    // Handshake decode and occupancy next state. A full stage may accept in
    // the same cycle it drains, giving one result per cycle.
    always_comb begin
        state_next = state;
        in_ready   = (state == S_EMPTY) || out_ready;
        out_valid  = (state == S_FULL);
        accept     = in_valid && in_ready;
        drain      = out_valid && out_ready;
        case (state)
            S_EMPTY: begin
                if (accept) begin
                    state_next = S_FULL;
                end
            end
            S_FULL: begin
                if (drain && !accept) begin
                    state_next = S_EMPTY;
                end
            end
            default: state_next = S_EMPTY;
        endcase
    end

    // Candidate flag values for an accepted result; unmasked bits hold. With
    // chain set, Z stays true only while every byte so far has been zero.
    always_comb begin
        sum_zero           = (sum == 8'h00);
        flags_calc         = flags;
        flags_calc[FLAG_Z] = chain ? (flags[FLAG_Z] & sum_zero) : sum_zero;
        flags_calc[FLAG_N] = sum[7];
        flags_calc[FLAG_C] = carry;
        flags_calc[FLAG_V] = overflow;
        flags_next         = (flags_calc & flag_mask) | (flags & ~flag_mask);
    end

    // Result and flag registers. A restore wins over the accept-time flag
    // update, but the accepted sum is still captured.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            result <= 8'h00;
            flags  <= RESET_FLAGS;
        end else begin
            if (accept) begin
                result <= sum;
            end
            if (flag_load) begin
                flags <= flag_din;
            end else if (accept) begin
                flags <= flags_next;
            end
        end
    end

    // Branch condition from the registered flags only (no forwarding).
    always_comb begin
        cond_true = 1'b0;
        case (cond_sel)
            3'd0:    cond_true = 1'b1;
            3'd1:    cond_true = flags[FLAG_Z];
            3'd2:    cond_true = ~flags[FLAG_Z];
            3'd3:    cond_true = flags[FLAG_C];
            3'd4:    cond_true = ~flags[FLAG_C];
            3'd5:    cond_true = flags[FLAG_N];
            3'd6:    cond_true = flags[FLAG_V];
            3'd7:    cond_true = flags[FLAG_N] ^ flags[FLAG_V];
            default: cond_true = 1'b0;
        endcase
    end

endmodule

`default_nettype wire

// File: doc/alu_result_stage.md
# alu_result_stage

Registered output stage directly downstream of the 8-bit carry-lookahead adder. It captures the adder's sum and its carry/borrow and overflow outputs into a one-entry pipeline register with a valid/ready handshake toward writeback. It also maintains the processor flag register (Z, N, C, V) with per-flag update masks, a multi-byte zero chain and a restore path. From the flags it drives a branch-condition output for the control unit.

## Interface
- RESET_FLAGS, 4'b0000: flag register value after reset, bit order {V,C,N,Z} = [3:0].
- clk  in  1  sole clock; all state updates on rising edge.
- rst_n  in  1  synchronous, active-low reset, sampled on rising edge of clk.
- in_valid  in  1  adder result presented this cycle.
- in_ready  out  1  stage can accept; = !full || out_ready (combinational).
- sum  in  8  adder `out`.
- carry  in  1  adder `carry` (cin ^ cout: carry for add, borrow for subtract).
- overflow  in  1  adder `overflow`.
- flag_mask  in  4  {V,C,N,Z} update enables, qualified by accept.
- chain  in  1  multi-byte op: Z accumulates instead of replacing.
- flag_load  in  1  restore flag register from flag_din.
- flag_din  in  4  restore value {V,C,N,Z}.
- cond_sel  in  3  branch condition select.
- out_valid  out  1  result register full.
- out_ready  in  1  writeback consumes result.
- result  out  8  registered sum.
- flags  out  4  flag register {V,C,N,Z}.
- cond_true  out  1  selected condition evaluated on current flags (combinational).

## Operation
- Accept = in_valid && in_ready. Drain = out_valid && out_ready.
- Occupancy:
  - EMPTY, accept → FULL.
  - FULL, drain without accept → EMPTY.
  - FULL, drain and accept in the same cycle → stays FULL with new data (pass-through).
  - FULL, !out_ready → hold; in_ready = 0; result and out_valid stable.
- On accept: result <= sum. Flags are updated bitwise where the flag_mask bit is 1:
  - Z <= (sum == 8'h00), or Z_old & (sum == 8'h00) when chain = 1.
  - N <= sum[7].
  - C <= carry.
  - V <= overflow.
- Unmasked flags hold. Flags update at accept time, not at drain.
- flag_load: flags <= flag_din. It has priority over the accept update in the same cycle. The accepted result is still captured.
- cond_sel decoding:
  - 0 always
  - 1 Z
  - 2 !Z
  - 3 C
  - 4 !C
  - 5 N
  - 6 V
  - 7 N^V (signed less-than)
- Data is never dropped or duplicated. in_valid without in_ready has no effect on any state.

## Timing
- Reset (rst_n low at clk edge): out_valid = 0, result = 8'h00, flags = RESET_FLAGS. cond_true follows flags (1 for cond_sel = 0).
- Reset mid-operation discards the held result regardless of out_ready. Reset overrides flag_load and accept.
- Latency: accept in cycle N → result, out_valid and flags visible in cycle N+1.
- Throughput: 1 result per cycle while out_ready stays high.
- in_ready depends combinationally on out_ready; there is no combinational path from in_valid to out_valid.
- cond_true reflects the register state only. It does not forward the flags of the operation being accepted in the same cycle.

## Test plan
- Reset, then one transfer:
  - Stimulus: rst_n low 2 cycles, release; sum = 8'h80, carry = 0, overflow = 1, mask = 4'hF, one-cycle in_valid.
  - Response: before the transfer, out_valid = 0, result = 0, flags = 0. After it, out_valid = 1, result = 8'h80, flags = {V1,C0,N1,Z0}.
  - Condition checks: cond_sel = 6 → 1; cond_sel = 7 → 0.
- Subtract 0x03 - 0x05:
  - Stimulus: sum = 8'hFE, carry = 1, overflow = 0, mask = 4'hF.
  - Response: flags = {0,1,1,0}; cond_sel = 3 → 1; cond_sel = 7 → 1.
- Multi-byte zero chain:
  - Stimulus: byte 0 with sum = 8'h00 and chain = 0, then byte 1 with sum = 8'h01 and chain = 1.
  - Response: Z = 1 after byte 0 and Z = 0 after byte 1. Repeating with byte 1 sum = 8'h00 keeps Z = 1.
- Backpressure:
  - Stimulus: out_ready = 0, three back-to-back in_valid with sums 8'h11, 8'h22, 8'h33.
  - Response: first accepted, then in_ready = 0 and result holds 8'h11. When out_ready rises, results drain 11, 22, 33 in order with no loss or duplicate.
  - Full-throughput check: out_ready held at 1 gives one result per cycle.
- Masks and restore:
  - mask = 4'b0001 with sum = 8'h80: only Z updates; N is unchanged.
  - flag_load with flag_din = 4'hA in the same cycle as an accept with mask = 4'hF: flags = 4'hA and result = new sum.
- Reset mid-stall: FULL with out_ready = 0, assert rst_n low for one cycle → out_valid = 0, result = 0, flags = RESET_FLAGS on the next cycle.
